tri_add_arbiter: RTL and testbench
==================================

Name: tri_add_arbiter

Overview:
- Shares one `thirty_two_bit_adder` (three-operand, 32-bit) instance among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on both sides.
- Operands are registered; the adder gets a fixed ADD_CYCLES multicycle settle window.
- The 34-bit result is registered and held until the consumer accepts it.
- Sits between the operand-producing units and the result sink; it is the only client-facing path to the adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADD_CYCLES, 2, clock cycles allowed for adder settle before result capture (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  32*NREQ  operand a; requester i occupies bits [32i+31:32i].
- req_b  input  32*NREQ  operand b, same packing.
- req_c  input  32*NREQ  operand c, same packing.
- req_cin  input  NREQ  carry-in per requester.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accept.
- rsp_sum  output  34  a+b+c+cin of the granted request, i.e. {Cout, S}.
- rsp_id  output  ID_W  index of the requester that owns rsp_sum; ID_W = max(1, clog2(NREQ)).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; rr pointer = 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_id = 0, busy = 0.
  - Operand registers = 0; req_ready = 0 while in reset.
- States: IDLE, CALC, RESP.
- IDLE:
  - Search req_valid starting at the rr pointer, wrapping at NREQ-1 to 0. The first set bit is the winner g.
  - req_ready[g] = 1, decoded combinationally from the registered state and pointer. All other req_ready bits = 0.
  - If no req_valid bit is set, req_ready = 0 and the state stays IDLE.
  - On a handshake (req_valid[g] & req_ready[g]) at edge T:
    - latch a, b, c, cin of requester g and latch rsp_id = g;
    - load settle counter = ADD_CYCLES-1; go to CALC.
- CALC:
  - Adder inputs are driven only from the operand registers.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture {Cout, S} into rsp_sum, set rsp_valid = 1, go to RESP.
  - Result: rsp_valid first high at edge T+ADD_CYCLES.
- RESP:
  - rsp_valid, rsp_sum and rsp_id stay stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid = 0, rr pointer = (rsp_id+1) mod NREQ, go to IDLE.
  - Minimum spacing between accepts: ADD_CYCLES+2 cycles.
- req_ready = 0 in CALC and RESP. Requests are never queued; only req_valid in the current IDLE cycle is sampled. A requester may drop valid before it is granted.
- Arithmetic:
  - Zero-extend the operands; rsp_sum = a+b+c+cin, 34 bits, no truncation.
  - Maximum value: 3*(2^32-1)+1 = 0x2_FFFF_FFFE.
  - The bench checks against a behavioural model, not against the adder's own outputs.
- Pointer wrap: after serving NREQ-1, the pointer becomes 0.
- Reset asserted mid-CALC or mid-RESP:
  - The transaction is dropped and all outputs return to reset values asynchronously.
  - No response is produced after reset is released.
- A requester that holds req_valid continuously is re-granted only after every other active requester has been served once.

Optional Feature:
- Macro: TRI_ADD_ARB_OVF_EN.
- Defined: adds output port rsp_ovf (1 bit).
  - Registered together with rsp_sum: rsp_ovf = |rsp_sum[33:32].
  - Reset value 0; held stable with rsp_sum during RESP.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Single request, requester 0: a=5, b=7, c=9, cin=1, rsp_ready=1 → req_ready[0] high at T; rsp_valid at T+2; rsp_sum=22; rsp_id=0; rsp_ovf=0.
- All four req_valid held high, rsp_ready=1, from reset → grants in order 0,1,2,3,0; each grant separated by 4 cycles; busy high between grants.
- Max operands: a=b=c=0xFFFFFFFF, cin=1 → rsp_sum=0x2_FFFF_FFFE; rsp_ovf=1.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_sum and rsp_id stable, every req_ready=0, no new grant; after rsp_ready=1, the next grant follows 1 cycle later.
- Reset pulse (rst_n=0 for 1 cycle) during CALC with requester 2 pending → rsp_valid=0 and busy=0 immediately; no response appears; the next grant starts from pointer 0.
- ADD_CYCLES=4 build, requesters 1 and 3 active → rsp_valid at T+4; grant order 1,3,1.

Source files
------------

// File: rtl/tri_add_arbiter.sv
// rtl/tri_add_arbiter.sv - round-robin arbiter sharing one three-operand 32-bit adder
// Define TRI_ADD_ARB_OVF_EN to add the registered rsp_ovf output.

module thirty_two_bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic        cin,
  output logic [31:0] s,
  output logic [1:0]  cout
);
  logic [33:0] total;

  assign total = {2'b00, a} + {2'b00, b} + {2'b00, c} + {33'd0, cin};
  assign s     = total[31:0];
  assign cout  = total[33:32];
endmodule

module tri_add_arbiter #(
  parameter  int NREQ       = 4,
  parameter  int ADD_CYCLES = 2,
  localparam int ID_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [32*NREQ-1:0]   req_c,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [33:0]          rsp_sum,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
`ifdef TRI_ADD_ARB_OVF_EN
  ,
  output logic                 rsp_ovf
`endif
);
  localparam int CNT_W = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       op_a, op_b, op_c;
  logic              op_cin;
  logic [31:0]       add_s;
  logic [1:0]        add_cout;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [ID_W-1:0]   off;
  logic [ID_W:0]     wsum;
  logic [ID_W-1:0]   win;
  logic              found;
  logic [31:0]       sel_a, sel_b, sel_c;
  logic              sel_cin;

  // Rotate req_valid so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl  = {req_valid, req_valid};
    rot  = NREQ'(dbl >> ptr);
    found = |rot;
    off  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = ID_W'(k);
    end
    wsum = {1'b0, ptr} + {1'b0, off};
    if (wsum >= (ID_W+1)'(NREQ)) wsum = wsum - (ID_W+1)'(NREQ);
    win = wsum[ID_W-1:0];

    sel_a   = '0;
    sel_b   = '0;
    sel_c   = '0;
    sel_cin = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == win) begin
        sel_a   = req_a[32*k +: 32];
        sel_b   = req_b[32*k +: 32];
        sel_c   = req_c[32*k +: 32];
        sel_cin = req_cin[k];
      end
    end
  end

  thirty_two_bit_adder u_adder (
    .a    (op_a),
    .b    (op_b),
    .c    (op_c),
    .cin  (op_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[win] = rst_n;
          state_nxt      = CALC;
        end
      end
      CALC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      op_cin    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
`ifdef TRI_ADD_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_c   <= sel_c;
            op_cin <= sel_cin;
            rsp_id <= win;
            cnt    <= CNT_W'(ADD_CYCLES - 1);
          end
        end
        CALC: begin
          if (cnt == '0) begin
            rsp_sum   <= {add_cout, add_s};
            rsp_valid <= 1'b1;
`ifdef TRI_ADD_ARB_OVF_EN
            rsp_ovf   <= |add_cout;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (rsp_id == ID_W'(NREQ - 1)) ? '0 : rsp_id + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tri_add_arbiter.sv
// tb/tb_tri_add_arbiter.sv - directed vector bench for tri_add_arbiter
// Covers TRI_ADD_ARB_OVF_EN builds when the macro is defined.

module tb_tri_add_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]   req_valid, req_ready, req_cin;
  logic [127:0] req_a, req_b, req_c;
  logic         rsp_valid, rsp_ready, busy;
  logic [33:0]  rsp_sum;
  logic [1:0]   rsp_id;

  logic [3:0]   req_valid4, req_ready4, req_cin4;
  logic [127:0] req_a4, req_b4, req_c4;
  logic         rsp_valid4, rsp_ready4, busy4;
  logic [33:0]  rsp_sum4;
  logic [1:0]   rsp_id4;
`ifdef TRI_ADD_ARB_OVF_EN
  logic         rsp_ovf, rsp_ovf4;
`endif

  tri_add_arbiter #(.NREQ(4), .ADD_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .busy(busy)
`ifdef TRI_ADD_ARB_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  tri_add_arbiter #(.NREQ(4), .ADD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4), .req_c(req_c4), .req_cin(req_cin4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_sum(rsp_sum4),
    .rsp_id(rsp_id4), .busy(busy4)
`ifdef TRI_ADD_ARB_OVF_EN
    , .rsp_ovf(rsp_ovf4)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] a, b, c;
    logic        cin;
    logic [33:0] sum;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_valid4 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    req_valid = '0; req_valid4 = '0;
    rsp_ready = 1'b1; rsp_ready4 = 1'b1;
    for (int i = 0; i < 20 && (busy || busy4); i++) @(negedge clk);
    check("drain_idle", {busy, busy4}, 2'b00);
  endtask

  task automatic run_vec(input vec_t v);
    int t_edge;
    req_a = '0; req_b = '0; req_c = '0; req_cin = '0;
    req_a[v.id*32 +: 32] = v.a;
    req_b[v.id*32 +: 32] = v.b;
    req_c[v.id*32 +: 32] = v.c;
    req_cin[v.id] = v.cin;
    req_valid = 4'b0001 << v.id;
    rsp_ready = 1'b1;
    #1;
    check("vec_grant", req_ready, 4'b0001 << v.id);
    @(negedge clk);
    t_edge = cyc;
    // Scramble inputs after the handshake: the result must come from the operand registers.
    req_valid = '0; req_a = '1; req_b = '1; req_c = '1; req_cin = '1;
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    check("vec_latency", cyc - t_edge, 2);
    check("vec_sum", rsp_sum, v.sum);
    check("vec_id", rsp_id, v.id);
`ifdef TRI_ADD_ARB_OVF_EN
    check("vec_ovf", rsp_ovf, v.ovf);
`endif
    @(negedge clk);
    check("vec_accept", {rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    logic [3:0] got [5];
    int         gc [5];
    int         ng, bad, rc0;
    logic       seen;

    vecs[0] = '{0, 32'd5,          32'd7,          32'd9,          1'b1, 34'h0_0000_0016, 1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 34'h2_FFFF_FFFE, 1'b1};
    vecs[2] = '{2, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 34'h1_0000_0000, 1'b1};
    vecs[3] = '{3, 32'd0,          32'd0,          32'd0,          1'b0, 34'h0_0000_0000, 1'b0};
    vecs[4] = '{3, 32'h8000_0000,  32'h8000_0000,  32'h8000_0000,  1'b1, 34'h1_8000_0001, 1'b1};
    vecs[5] = '{1, 32'h1234_5678,  32'h1111_1111,  32'h0101_0101,  1'b0, 34'h0_2446_688A, 1'b0};
    vecs[6] = '{0, 32'hFFFF_FFFF,  32'd0,          32'd0,          1'b1, 34'h1_0000_0000, 1'b1};
    vecs[7] = '{2, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd1,          1'b0, 34'h0_FFFF_FFFF, 1'b0};

    req_valid = 4'hF; req_a = '0; req_b = '0; req_c = '0; req_cin = '0; rsp_ready = 1'b0;
    req_valid4 = '0; req_a4 = '0; req_b4 = '0; req_c4 = '0; req_cin4 = '0; rsp_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", req_ready, 4'b0000);
    check("reset_outputs", {rsp_valid, rsp_sum, rsp_id, busy}, '0);
    do_reset();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Round robin with all requesters held valid.
    do_reset();
    req_a = {32'd4, 32'd3, 32'd2, 32'd1};
    req_b = {32'd40, 32'd30, 32'd20, 32'd10};
    req_c = '0; req_cin = '0;
    req_valid = 4'hF; rsp_ready = 1'b1;
    ng = 0; bad = 0;
    for (int i = 0; i < 60 && ng < 5; i++) begin
      #1;
      if (req_ready != 4'b0000) begin
        got[ng] = req_ready; gc[ng] = cyc; ng++;
        if (busy) bad++;
      end else if (!busy) bad++;
      @(negedge clk);
    end
    check("rr_count", ng, 5);
    check("rr_g0", got[0], 4'b0001);
    check("rr_g1", got[1], 4'b0010);
    check("rr_g2", got[2], 4'b0100);
    check("rr_g3", got[3], 4'b1000);
    check("rr_g4", got[4], 4'b0001);
    for (int i = 1; i < 5; i++) check("rr_spacing", gc[i] - gc[i-1], 4);
    check("rr_busy", bad, 0);
    drain();

    // Backpressure: result held, no new grant until accepted.
    do_reset();
    req_valid = 4'b1101; rsp_ready = 1'b0;
    #1;
    check("bp_grant", req_ready, 4'b0001);
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_sum !== 34'd11 || rsp_id !== 2'd0 ||
          req_ready !== 4'b0000 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    check("bp_hold", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_next_grant", req_ready, 4'b0100);
    check("bp_released", rsp_valid, 1'b0);
    drain();

    // Reset pulse while requester 2 is in CALC; pointer must return to 0.
    do_reset();
    req_valid = 4'b0010; rsp_ready = 1'b1;
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    check("rst_pre_grant", req_ready, 4'b0100);
    @(negedge clk);
    check("rst_in_calc", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {rsp_valid, busy, req_ready}, 6'b0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    check("rst_no_rsp", seen, 1'b0);
    req_valid = 4'hF;
    #1;
    check("rst_ptr_zero", req_ready, 4'b0001);
    drain();

    // ADD_CYCLES=4 instance, requesters 1 and 3 active.
    do_reset();
    req_a4 = {32'd30, 32'd0, 32'd10, 32'd0};
    req_b4 = {32'd3, 32'd0, 32'd1, 32'd0};
    req_valid4 = 4'b1010; rsp_ready4 = 1'b1;
    ng = 0; rc0 = -1;
    for (int i = 0; i < 60 && ng < 3; i++) begin
      #1;
      if (req_ready4 != 4'b0000) begin got[ng] = req_ready4; gc[ng] = cyc; ng++; end
      if (rsp_valid4 && rc0 < 0) begin
        rc0 = cyc;
        check("a4_sum", rsp_sum4, 34'd11);
        check("a4_id", rsp_id4, 2'd1);
      end
      @(negedge clk);
    end
    check("a4_count", ng, 3);
    check("a4_g0", got[0], 4'b0010);
    check("a4_g1", got[1], 4'b1000);
    check("a4_g2", got[2], 4'b0010);
    check("a4_latency", rc0 - (gc[0] + 1), 4);
    check("a4_spacing", gc[1] - gc[0], 6);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
